// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg
// Shared seven-segment definitions. The pattern constants are used by the
// display driver (encode) and by seg7_capture (decode), so both directions
// always agree on the glyph set.
//   seg_t    : segment pattern {a,b,c,d,e,f,g}, active-high
//   nibble_t : hex digit value
// ----------------------------------------------------------------------------
package seg7_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] nibble_t;

    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;
    localparam seg_t SEG_A     = 7'b1110111;
    localparam seg_t SEG_B     = 7'b0011111;
    localparam seg_t SEG_C     = 7'b1001110;
    localparam seg_t SEG_D     = 7'b0111101;
    localparam seg_t SEG_E     = 7'b1001111;
    localparam seg_t SEG_F     = 7'b1000111;
    localparam seg_t SEG_BLANK = 7'b0000000;

    // Encode helper for the driver side.
    function automatic seg_t seg_encode(input nibble_t n);
        seg_t s;
        case (n)
            4'h0: s = SEG_0;
            4'h1: s = SEG_1;
            4'h2: s = SEG_2;
            4'h3: s = SEG_3;
            4'h4: s = SEG_4;
            4'h5: s = SEG_5;
            4'h6: s = SEG_6;
            4'h7: s = SEG_7;
            4'h8: s = SEG_8;
            4'h9: s = SEG_9;
            4'hA: s = SEG_A;
            4'hB: s = SEG_B;
            4'hC: s = SEG_C;
            4'hD: s = SEG_D;
            4'hE: s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// ----------------------------------------------------------------------------
// seg7_decode
// Combinational pattern-to-nibble decoder.
//   seg_i    : segment pattern {a,b,c,d,e,f,g}
//   legal_o  : pattern is one of the 16 hex glyphs
//   blank_o  : pattern is all segments off
//   nibble_o : decoded value (0 unless legal_o)
// ----------------------------------------------------------------------------
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       legal_o,
    output logic       blank_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        legal_o  = 1'b1;
        blank_o  = 1'b0;
        nibble_o = 4'h0;
        case (seg_i)
            SEG_0: nibble_o = 4'h0;
            SEG_1: nibble_o = 4'h1;
            SEG_2: nibble_o = 4'h2;
            SEG_3: nibble_o = 4'h3;
            SEG_4: nibble_o = 4'h4;
            SEG_5: nibble_o = 4'h5;
            SEG_6: nibble_o = 4'h6;
            SEG_7: nibble_o = 4'h7;
            SEG_8: nibble_o = 4'h8;
            SEG_9: nibble_o = 4'h9;
            SEG_A: nibble_o = 4'hA;
            SEG_B: nibble_o = 4'hB;
            SEG_C: nibble_o = 4'hC;
            SEG_D: nibble_o = 4'hD;
            SEG_E: nibble_o = 4'hE;
            SEG_F: nibble_o = 4'hF;
            SEG_BLANK: begin
                legal_o = 1'b0;
                blank_o = 1'b1;
            end
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// ----------------------------------------------------------------------------
// seg7_capture
// Watches a multiplexed seven-segment bus and recovers the nibble shown on
// each digit. A {pattern, select} pair must be seen unchanged on
// STABLE_CYCLES+1 consecutive edges before it is accepted, which filters
// multiplexing ghosts and switching glitches.
//   clk, rst_n    : clock, asynchronous active-low reset
//   seg_in        : segment pattern {a,b,c,d,e,f,g}, active-high
//   dig_sel       : one-hot digit select, active-high
//   clear         : synchronous clear of all captured state
//   digits_out    : captured nibbles, digit i at [4i+3:4i]
//   digit_valid   : digit i holds a decoded value
//   upd_*         : single-entry valid/ready stream of digit changes
//   err_invalid   : sticky, an illegal non-blank pattern was accepted
//   err_overflow  : sticky, an update event was dropped
// ----------------------------------------------------------------------------
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    upd_valid,
    input  logic                    upd_ready,
    output logic [2:0]              upd_idx,
    output logic [3:0]              upd_value,
    output logic                    err_invalid,
    output logic                    err_overflow
);

    localparam int CNT_W = 4;

    // Input sample registers
    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] sel_q;

    // Stability tracking
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fired_q, fired_d;

    // Register file
    logic [NUM_DIGITS-1:0][3:0] dig_q, dig_d;
    logic [NUM_DIGITS-1:0]      vld_q, vld_d;

    // Update register and sticky errors
    logic       upd_valid_q, upd_valid_d;
    logic [2:0] upd_idx_q, upd_idx_d;
    logic [3:0] upd_val_q, upd_val_d;
    logic       err_inv_q, err_inv_d;
    logic       err_ovf_q, err_ovf_d;

    logic       match, accept, new_ev;
    logic       dec_legal, dec_blank;
    logic [3:0] dec_nib;
    logic [2:0] cur_idx;
    logic [3:0] cur_nib;
    logic       cur_vld;

    seg7_decode u_dec (
        .seg_i   (seg_q),
        .legal_o (dec_legal),
        .blank_o (dec_blank),
        .nibble_o(dec_nib)
    );

    // The live input equalling the registered sample means the bus held
    // still across this edge; zero or multi-hot selects never count.
    assign match  = (seg_in == seg_q) && (dig_sel == sel_q) && $onehot(dig_sel);

    // fired_q blocks a second accept within the same run, e.g. after a
    // clear restarts the counter while the bus keeps the same value.
    assign accept = match && !clear && !fired_q &&
                    (cnt_q == CNT_W'(STABLE_CYCLES - 1));

    // Index and current contents of the selected digit.
    always_comb begin
        cur_idx = 3'd0;
        cur_nib = 4'h0;
        cur_vld = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_q[i]) begin
                cur_idx = 3'(i);
                cur_nib = dig_q[i];
                cur_vld = vld_q[i];
            end
        end
    end

    // Only genuine changes are reported; re-showing the same value is silent.
    assign new_ev = accept && dec_legal && (!cur_vld || (cur_nib != dec_nib));

    // Stability counter and run arming.
    always_comb begin
        cnt_d   = cnt_q;
        fired_d = fired_q;
        if (!match) begin
            cnt_d   = '0;
            fired_d = 1'b0;
        end else begin
            if (cnt_q != CNT_W'(STABLE_CYCLES))
                cnt_d = cnt_q + 1'b1;
            if (accept)
                fired_d = 1'b1;
        end
        if (clear)
            cnt_d = '0;
    end

    // Register file, update register, error flags.
    always_comb begin
        dig_d       = dig_q;
        vld_d       = vld_q;
        err_inv_d   = err_inv_q;
        err_ovf_d   = err_ovf_q;
        upd_valid_d = upd_valid_q;
        upd_idx_d   = upd_idx_q;
        upd_val_d   = upd_val_q;
        if (clear) begin
            dig_d       = '0;
            vld_d       = '0;
            err_inv_d   = 1'b0;
            err_ovf_d   = 1'b0;
            upd_valid_d = 1'b0;
            upd_idx_d   = '0;
            upd_val_d   = '0;
        end else begin
            if (accept) begin
                if (!dec_legal && !dec_blank)
                    err_inv_d = 1'b1;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (sel_q[i]) begin
                        if (dec_legal) begin
                            dig_d[i] = dec_nib;
                            vld_d[i] = 1'b1;
                        end else if (dec_blank) begin
                            // Blank keeps the stored nibble for diagnostics.
                            vld_d[i] = 1'b0;
                        end
                    end
                end
            end

            if (upd_valid_q && upd_ready)
                upd_valid_d = 1'b0;

            if (new_ev) begin
                // Loads on an empty slot or on a simultaneous pop.
                if (!upd_valid_q || upd_ready) begin
                    upd_valid_d = 1'b1;
                    upd_idx_d   = cur_idx;
                    upd_val_d   = dec_nib;
                end else begin
                    err_ovf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q       <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            fired_q     <= 1'b0;
            dig_q       <= '0;
            vld_q       <= '0;
            upd_valid_q <= 1'b0;
            upd_idx_q   <= '0;
            upd_val_q   <= '0;
            err_inv_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            seg_q       <= seg_in;
            sel_q       <= dig_sel;
            cnt_q       <= cnt_d;
            fired_q     <= fired_d;
            dig_q       <= dig_d;
            vld_q       <= vld_d;
            upd_valid_q <= upd_valid_d;
            upd_idx_q   <= upd_idx_d;
            upd_val_q   <= upd_val_d;
            err_inv_q   <= err_inv_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    assign digits_out   = dig_q;
    assign digit_valid  = vld_q;
    assign upd_valid    = upd_valid_q;
    assign upd_idx      = upd_idx_q;
    assign upd_value    = upd_val_q;
    assign err_invalid  = err_inv_q;
    assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_seg7_capture.sv
// ----------------------------------------------------------------------------
// tb_seg7_capture
// Directed bench for seg7_capture (NUM_DIGITS=4, STABLE_CYCLES=3). Expected
// update events go into a queue when the stimulus is driven and are popped
// by a monitor whenever the DUT hands one over.
// ----------------------------------------------------------------------------
module tb_seg7_capture;

    localparam int ND = 4;
    localparam int SC = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    seg_in = '0;
    logic [ND-1:0] dig_sel = '0;
    logic          clear = 1'b0;
    logic [4*ND-1:0] digits_out;
    logic [ND-1:0] digit_valid;
    logic          upd_valid;
    logic          upd_ready = 1'b1;
    logic [2:0]    upd_idx;
    logic [3:0]    upd_value;
    logic          err_invalid;
    logic          err_overflow;

    seg7_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .clear       (clear),
        .digits_out  (digits_out),
        .digit_valid (digit_valid),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_idx     (upd_idx),
        .upd_value   (upd_value),
        .err_invalid (err_invalid),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] idx;
        logic [3:0] val;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_ev  = 0;

    logic [6:0] tbl [16];
    logic [3:0] mval [ND];
    logic       mvld [ND];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic [6:0] s, input logic [ND-1:0] d);
        seg_in  = s;
        dig_sel = d;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [4*ND-1:0] model_digits();
        logic [4*ND-1:0] r;
        r = '0;
        for (int i = 0; i < ND; i++) r[4*i +: 4] = mval[i];
        return r;
    endfunction

    // Handshake happens on the next rising edge; compare against scoreboard.
    always @(negedge clk) begin
        if (rst_n && upd_valid && upd_ready) begin
            chk("event_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("upd_idx", 32'(upd_idx), 32'(mon_e.idx));
                chk("upd_value", 32'(upd_value), 32'(mon_e.val));
                n_ev++;
            end
        end
    end

    initial begin
        tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

        // Reset state
        tick(2);
        chk("reset_outputs", 32'({digits_out, digit_valid, upd_valid, err_invalid, err_overflow}), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // Single stable digit: accept exactly at the 4th edge
        exp_q.push_back('{idx: 3'd0, val: 4'h2});
        drive(7'b1101101, 4'b0001);
        tick(3);
        chk("pre_accept_valid", 32'(digit_valid), 32'd0);
        tick(1);
        chk("accept_digit0", 32'(digits_out[3:0]), 32'h2);
        chk("accept_valid0", 32'(digit_valid), 32'b0001);
        tick(1);
        chk("one_event", 32'(n_ev), 32'd1);
        chk("upd_drained", 32'(upd_valid), 32'd0);

        // Glitchy bus: 2-cycle and 3-cycle holds never accept
        drive(tbl[7], 4'b0010); tick(2);
        drive(tbl[8], 4'b0010); tick(2);
        drive(tbl[9], 4'b0010); tick(2);
        drive(tbl[6], 4'b0010); tick(2);
        drive(tbl[0], 4'b0010); tick(2);
        drive(tbl[4], 4'b0010); tick(3);
        drive(tbl[11], 4'b0010); tick(3);
        chk("glitch_valid", 32'(digit_valid), 32'b0001);
        chk("glitch_events", 32'(n_ev), 32'd1);

        // Repeated value on digit 2 reports once; blank clears valid only
        exp_q.push_back('{idx: 3'd2, val: 4'h3});
        drive(7'b1111001, 4'b0100); tick(5);
        exp_q.push_back('{idx: 3'd0, val: 4'h1});
        drive(7'b0110000, 4'b0001); tick(5);
        drive(7'b1111001, 4'b0100); tick(5);
        chk("repeat_digit2", 32'(digits_out[11:8]), 32'h3);
        chk("repeat_valid", 32'(digit_valid), 32'b0101);
        chk("repeat_events", 32'(n_ev), 32'd3);
        drive(7'b0000000, 4'b0100); tick(5);
        chk("blank_valid", 32'(digit_valid), 32'b0001);
        chk("blank_keeps_slot", 32'(digits_out[11:8]), 32'h3);
        chk("blank_no_err", 32'(err_invalid), 32'd0);

        // Illegal pattern then clear
        drive(7'b1010101, 4'b0010); tick(5);
        chk("invalid_err", 32'(err_invalid), 32'd1);
        chk("invalid_slot", 32'(digits_out), 32'h0301);
        chk("invalid_valid", 32'(digit_valid), 32'b0001);
        drive(7'b0000000, 4'b0000);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("clear_err", 32'(err_invalid), 32'd0);
        chk("clear_all", 32'({digits_out, digit_valid, upd_valid, err_invalid, err_overflow}), 32'd0);

        // Overflow with ready low, then pop-and-push
        upd_ready = 1'b0;
        exp_q.push_back('{idx: 3'd0, val: 4'h5});
        drive(tbl[5], 4'b0001); tick(5);
        chk("held_valid", 32'(upd_valid), 32'd1);
        chk("held_value", 32'({upd_idx, upd_value}), 32'({3'd0, 4'h5}));
        chk("no_ovf_yet", 32'(err_overflow), 32'd0);
        drive(tbl[12], 4'b1000); tick(5);
        chk("ovf_set", 32'(err_overflow), 32'd1);
        chk("ovf_held", 32'({upd_idx, upd_value}), 32'({3'd0, 4'h5}));
        chk("ovf_slot3", 32'(digits_out[15:12]), 32'hC);
        exp_q.push_back('{idx: 3'd1, val: 4'hE});
        drive(tbl[14], 4'b0010); tick(3);
        upd_ready = 1'b1;
        tick(1);
        chk("popush_valid", 32'(upd_valid), 32'd1);
        chk("popush_value", 32'({upd_idx, upd_value}), 32'({3'd1, 4'hE}));
        tick(2);
        chk("ovf_events", 32'(n_ev), 32'd5);
        chk("ovf_queue", 32'(exp_q.size()), 32'd0);

        // Walk all 16 glyphs with multi-hot select glitches between them
        drive(7'b0000000, 4'b0000);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        for (int i = 0; i < ND; i++) begin
            mval[i] = 4'h0;
            mvld[i] = 1'b0;
        end
        for (int v = 0; v < 16; v++) begin
            int d;
            d = v % ND;
            drive(tbl[v], 4'b0110); tick(4);
            chk("multihot_digits", 32'(digits_out), 32'(model_digits()));
            if (!mvld[d] || mval[d] != 4'(v))
                exp_q.push_back('{idx: 3'(d), val: 4'(v)});
            mval[d] = 4'(v);
            mvld[d] = 1'b1;
            drive(tbl[v], 4'(1 << d)); tick(4);
            chk("walk_digits", 32'(digits_out), 32'(model_digits()));
        end
        tick(2);
        chk("walk_valid", 32'(digit_valid), 32'b1111);
        chk("walk_events", 32'(n_ev), 32'd21);
        chk("walk_queue", 32'(exp_q.size()), 32'd0);

        // Reset mid-run discards the partial count
        exp_q.push_back('{idx: 3'd3, val: 4'h9});
        drive(tbl[9], 4'b1000); tick(2);
        rst_n = 1'b0;
        #1;
        chk("async_reset", 32'({digits_out, digit_valid}), 32'd0);
        #2;
        rst_n = 1'b1;
        tick(3);
        chk("rst_run_early", 32'(digit_valid), 32'd0);
        tick(1);
        chk("rst_run_accept", 32'(digit_valid), 32'b1000);
        chk("rst_run_digit", 32'(digits_out[15:12]), 32'h9);
        tick(2);
        chk("final_events", 32'(n_ev), 32'd22);
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
